data_memory_ctrl: RTL and testbench

Parametrised data memory for the RV32IM pipeline's MEM stage. Replaces the fixed 1 KiB byte memory with:
- a word-organised RAM of configurable depth with byte-lane writes;
- a valid/ready request port and a registered, one-cycle-latency response;
- signed and unsigned load extension;
- misaligned accesses either split into two word accesses by a small FSM or rejected with a fault.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_byte_ram.sv | 25 ++
 rtl/data_memory_ctrl.sv | 148 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory controller:
// RV32 load/store funct3 encodings, controller states and access sizing.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_t;

  // Access size in bytes; illegal encodings report 4 and are faulted elsewhere.
  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: access_size = 3'd1;
      F3_H, F3_HU: access_size = 3'd2;
      default:     access_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port. Contents are intentionally not reset.
module dmem_byte_ram #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: valid/ready request port, one-cycle registered response,
// load extension, and word-crossing accesses split over two RAM cycles.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS      = 256,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      F3_B:    load_extend = {{24{d[7]}}, d[7:0]};
      F3_H:    load_extend = {{16{d[15]}}, d[15:0]};
      F3_BU:   load_extend = {24'b0, d[7:0]};
      F3_HU:   load_extend = {16'b0, d[15:0]};
      default: load_extend = d;
    endcase
  endfunction

  state_t        state;
  logic          accept, illegal, misaligned, crossing, fault, go_split;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [2:0]    size;
  logic [3:0]    size_mask;
  logic [7:0]    be64;
  logic [63:0]   wd64;
  logic          unused_addr;

  // Request context captured at accept, held through SPLIT and the response cycle
  logic [2:0]    f3_p0;
  logic [1:0]    off_p0;
  logic          write_p0;
  logic [AW-1:0] idx_hi_p0;
  logic [3:0]    be_hi_p0;
  logic [31:0]   hold_p0;
  logic          resp_split;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic [31:0]   lo_word, aligned;

  assign req_ready   = (state == IDLE);
  assign accept      = req_valid && req_ready;
  assign idx         = req_addr[AW+1:2];
  assign off         = req_addr[1:0];
  assign size        = access_size(req_funct3);
  assign unused_addr = ^req_addr[31:AW+2];

  always_comb begin
    case (size)
      3'd1:    size_mask = 4'h1;
      3'd2:    size_mask = 4'h3;
      default: size_mask = 4'hF;
    endcase
  end

  // Lanes and data spread across a 64-bit window: low half = word i, high half = word i+1
  assign be64 = {4'b0000, size_mask} << off;
  assign wd64 = {32'b0, req_wdata} << {off, 3'b000};

  assign misaligned = ((size == 3'd2) && off[0]) || ((size == 3'd4) && (off != 2'b00));
  assign crossing   = ({1'b0, off} + size) > 3'd4;
  assign illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                      (req_write && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU)));
  assign fault      = illegal || (misaligned && !ALLOW_MISALIGNED);
  assign go_split   = accept && !fault && crossing;

  // RAM gated off while reset is held so an aborted split never finishes its write
  always_comb begin
    ram_en    = 1'b0;
    ram_addr  = idx;
    ram_we    = 4'h0;
    ram_wdata = wd64[31:0];
    if (state == SPLIT) begin
      ram_en    = !reset;
      ram_addr  = idx_hi_p0;
      ram_we    = write_p0 ? be_hi_p0 : 4'h0;
      ram_wdata = hold_p0;
    end else if (accept && !fault) begin
      ram_en = !reset;
      ram_we = req_write ? be64[3:0] : 4'h0;
    end
  end

  dmem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_split <= 1'b0;
    end else if (state == SPLIT) begin
      state      <= IDLE;
      resp_valid <= 1'b1;
      resp_fault <= 1'b0;
      resp_split <= 1'b1;
    end else begin
      state      <= go_split ? SPLIT : IDLE;
      resp_valid <= accept && !go_split;
      resp_fault <= accept && fault;
      resp_split <= 1'b0;
    end
  end

  // For split stores hold_p0 carries the high-word data; for split loads it keeps word i
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_p0     <= req_funct3;
      off_p0    <= off;
      write_p0  <= req_write;
      idx_hi_p0 <= idx + {{(AW-1){1'b0}}, 1'b1};
      be_hi_p0  <= be64[7:4];
      hold_p0   <= wd64[63:32];
    end else if ((state == SPLIT) && !write_p0) begin
      hold_p0   <= ram_rdata;
    end
  end

  assign lo_word    = resp_split ? hold_p0 : ram_rdata;
  assign aligned    = 32'({ram_rdata, lo_word} >> {off_p0, 3'b000});
  assign resp_rdata = (resp_valid && !resp_fault && !write_p0) ? load_extend(aligned, f3_p0) : 32'b0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: a byte-level reference memory predicts
// each response at accept time; monitors compare responses as they appear.
module tb_data_memory_ctrl;

  localparam int D  = 64;
  localparam int MB = 4 * D;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
  logic        req_ready, resp_valid, resp_fault;
  logic [31:0] resp_rdata;

  logic        n_req_valid = 1'b0, n_req_write = 1'b0;
  logic [2:0]  n_req_funct3 = 3'b0;
  logic [31:0] n_req_addr = 32'b0, n_req_wdata = 32'b0;
  logic        n_req_ready, n_resp_valid, n_resp_fault;
  logic [31:0] n_resp_rdata;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t sb_nm[$];
  exp_t e_mon, e_mon_nm;
  logic [7:0] mem_m [MB];

  data_memory_ctrl #(.DEPTH_WORDS(D), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault)
  );

  data_memory_ctrl #(.DEPTH_WORDS(D), .ALLOW_MISALIGNED(1'b0)) dut_nm (
    .clk(clk), .reset(reset), .req_valid(n_req_valid), .req_ready(n_req_ready),
    .req_write(n_req_write), .req_funct3(n_req_funct3), .req_addr(n_req_addr),
    .req_wdata(n_req_wdata), .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata),
    .resp_fault(n_resp_fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned m_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit m_fault(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input bit allow);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (wr && (f3 == 3'b100 || f3 == 3'b101)) return 1'b1;
    if (!allow && (addr % m_size(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v;
    v = 32'b0;
    for (int k = 0; k < int'(m_size(f3)); k++) v[8*k +: 8] = mem_m[(addr + k) % MB];
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic issue(input string tag, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    int   guard;
    exp_t e;
    guard = 0;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    while (!req_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      check_eq({tag, "_ready_timeout"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    e.tag = tag; e.rdata = 32'b0; e.fault = m_fault(wr, f3, addr, 1'b1);
    if (!e.fault) begin
      if (wr) for (int k = 0; k < int'(m_size(f3)); k++) mem_m[(addr + k) % MB] = wd[8*k +: 8];
      else e.rdata = m_load(f3, addr);
    end
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic issue_nm(input string tag, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_fault);
    exp_t e;
    n_req_valid = 1'b1; n_req_write = wr; n_req_funct3 = f3; n_req_addr = addr; n_req_wdata = wd;
    check_eq({tag, "_ready"}, {31'b0, n_req_ready}, 32'd1);
    e.tag = tag; e.rdata = exp_rdata; e.fault = exp_fault;
    sb_nm.push_back(e);
    @(posedge clk); #1;
    n_req_valid = 1'b0;
    check_eq({tag, "_valid_t1"}, {31'b0, n_resp_valid}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) check_eq("spurious_resp", {31'b0, resp_valid}, 32'd0);
      else begin
        e_mon = sb.pop_front();
        check_eq({e_mon.tag, "_rdata"}, resp_rdata, e_mon.rdata);
        check_eq({e_mon.tag, "_fault"}, {31'b0, resp_fault}, {31'b0, e_mon.fault});
      end
    end
  end

  always @(negedge clk) begin
    if (n_resp_valid) begin
      if (sb_nm.size() == 0) check_eq("nm_spurious_resp", {31'b0, n_resp_valid}, 32'd0);
      else begin
        e_mon_nm = sb_nm.pop_front();
        check_eq({e_mon_nm.tag, "_rdata"}, n_resp_rdata, e_mon_nm.rdata);
        check_eq({e_mon_nm.tag, "_fault"}, {31'b0, n_resp_fault}, {31'b0, e_mon_nm.fault});
      end
    end
  end

  initial begin
    int guard;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_fault", {31'b0, resp_fault}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int w = 0; w < D; w++) issue("init", 1'b1, 3'b010, 32'(4 * w), 32'd0);

    // Basic word store/load, back-to-back
    issue("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check_eq("sw_10_valid_t1", {31'b0, resp_valid}, 32'd1);
    check_eq("sw_10_ready_t1", {31'b0, req_ready}, 32'd1);
    issue("lw_10", 1'b0, 3'b010, 32'h10, 32'h0);

    // Byte/half extension
    issue("sw_20", 1'b1, 3'b010, 32'h20, 32'h11223344);
    issue("sb_21", 1'b1, 3'b000, 32'h21, 32'hABCDEF80);
    issue("lb_21", 1'b0, 3'b000, 32'h21, 32'h0);
    issue("lbu_21", 1'b0, 3'b100, 32'h21, 32'h0);
    issue("lh_20", 1'b0, 3'b001, 32'h20, 32'h0);
    issue("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0);
    issue("lb_23", 1'b0, 3'b000, 32'h23, 32'h0);

    // Word-crossing store and load
    issue("sw_00", 1'b1, 3'b010, 32'h00, 32'hA1A2A3A4);
    issue("sw_04", 1'b1, 3'b010, 32'h04, 32'hB1B2B3B4);
    issue("sw_03", 1'b1, 3'b010, 32'h03, 32'h11223344);
    check_eq("split_ready_t1", {31'b0, req_ready}, 32'd0);
    check_eq("split_valid_t1", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq("split_ready_t2", {31'b0, req_ready}, 32'd1);
    check_eq("split_valid_t2", {31'b0, resp_valid}, 32'd1);
    issue("lw_03", 1'b0, 3'b010, 32'h03, 32'h0);
    issue("lw_00", 1'b0, 3'b010, 32'h00, 32'h0);
    issue("lw_04", 1'b0, 3'b010, 32'h04, 32'h0);
    issue("lh_01", 1'b0, 3'b001, 32'h01, 32'h0);
    issue("lhu_07", 1'b0, 3'b101, 32'h07, 32'h0);

    // Wrap at top of memory
    issue("sw_top", 1'b1, 3'b010, 32'(MB - 4), 32'hC1C2C3C4);
    issue("sw_w0", 1'b1, 3'b010, 32'h00, 32'h5566F788);
    issue("lh_wrap", 1'b0, 3'b001, 32'(MB - 1), 32'h0);
    issue("lw_alias", 1'b0, 3'b010, 32'(MB), 32'h0);
    issue("sw_wrap", 1'b1, 3'b010, 32'(MB - 2), 32'h0BADF00D);
    issue("lw_wrap", 1'b0, 3'b010, 32'(MB - 2), 32'h0);

    // Illegal encodings fault and leave memory untouched
    issue("sw_30", 1'b1, 3'b010, 32'h30, 32'h76543210);
    issue("sh_f101", 1'b1, 3'b101, 32'h30, 32'hFFFFFFFF);
    issue("sb_f100", 1'b1, 3'b100, 32'h31, 32'hFFFFFFFF);
    issue("lw_30", 1'b0, 3'b010, 32'h30, 32'h0);
    issue("ld_f011", 1'b0, 3'b011, 32'h30, 32'h0);
    issue("ld_f110", 1'b0, 3'b110, 32'h30, 32'h0);

    // Reset during SPLIT of a crossing store
    issue("sw_04b", 1'b1, 3'b010, 32'h04, 32'h01020304);
    issue("sw_08b", 1'b1, 3'b010, 32'h08, 32'h05060708);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h07; req_wdata = 32'h99887766;
    check_eq("abort_pre_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_m[7] = 8'h66;
    check_eq("abort_in_split", {31'b0, req_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check_eq("abort_ready_async", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    check_eq("abort_no_resp", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_ready_after", {31'b0, req_ready}, 32'd1);
    check_eq("abort_no_resp2", {31'b0, resp_valid}, 32'd0);
    issue("lw_04_abort", 1'b0, 3'b010, 32'h04, 32'h0);
    issue("lw_08_abort", 1'b0, 3'b010, 32'h08, 32'h0);

    // Mixed random traffic against the reference model
    for (int i = 0; i < 60; i++)
      issue("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 300)), $urandom);

    // Controller with misaligned accesses rejected
    issue_nm("nm_sw_08", 1'b1, 3'b010, 32'h08, 32'h12345678, 32'h0, 1'b0);
    issue_nm("nm_lw_08", 1'b0, 3'b010, 32'h08, 32'h0, 32'h12345678, 1'b0);
    issue_nm("nm_lw_02", 1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1);
    issue_nm("nm_lh_01", 1'b0, 3'b001, 32'h01, 32'h0, 32'h0, 1'b1);
    issue_nm("nm_sw_09", 1'b1, 3'b010, 32'h09, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue_nm("nm_sh_0a", 1'b1, 3'b001, 32'h0B, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue_nm("nm_lw_08b", 1'b0, 3'b010, 32'h08, 32'h0, 32'h12345678, 1'b0);
    issue_nm("nm_lhu_0a", 1'b0, 3'b101, 32'h0A, 32'h0, 32'h00001234, 1'b0);

    guard = 0;
    while ((sb.size() != 0 || sb_nm.size() != 0) && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("drain_main", 32'(sb.size()), 32'd0);
    check_eq("drain_nm", 32'(sb_nm.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
